// File: rtl/sort_11_drain.sv
// rtl/sort_11_drain.sv - captures an 11-word parallel frame and drains it one word per handshake.
// Optional adjacent-pair order checking is enabled by defining SORT_ORDER_CHECK_EN.
module sort_11_drain #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sort_0,
    input  logic [WIDTH-1:0] sort_1,
    input  logic [WIDTH-1:0] sort_2,
    input  logic [WIDTH-1:0] sort_3,
    input  logic [WIDTH-1:0] sort_4,
    input  logic [WIDTH-1:0] sort_5,
    input  logic [WIDTH-1:0] sort_6,
    input  logic [WIDTH-1:0] sort_7,
    input  logic [WIDTH-1:0] sort_8,
    input  logic [WIDTH-1:0] sort_9,
    input  logic [WIDTH-1:0] sort_10,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_index,
    output logic             out_last,
    output logic             order_err
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd10;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [WIDTH-1:0] bank_q [11];
    logic [WIDTH-1:0] bank_d [11];
    logic [WIDTH-1:0] in_words [11];
    logic             capture;

    always_comb begin
        in_words[0]  = sort_0;
        in_words[1]  = sort_1;
        in_words[2]  = sort_2;
        in_words[3]  = sort_3;
        in_words[4]  = sort_4;
        in_words[5]  = sort_5;
        in_words[6]  = sort_6;
        in_words[7]  = sort_7;
        in_words[8]  = sort_8;
        in_words[9]  = sort_9;
        in_words[10] = sort_10;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bank_d    = bank_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture = 1'b1;
                    state_d = EMIT;
                    idx_d   = 4'd0;
                    bank_d  = in_words;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 4'd0;
            end
        endcase
    end

    // Outputs are gated by out_valid so stale bank contents never leak while idle.
    always_comb begin
        out_data  = out_valid ? bank_q[idx_q] : '0;
        out_index = out_valid ? idx_q : 4'd0;
        out_last  = out_valid && (idx_q == LAST_IDX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

`ifdef SORT_ORDER_CHECK_EN
    logic order_err_q, order_err_d;
    logic order_viol;

    always_comb begin
        order_viol = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (in_words[i] > in_words[i+1]) begin
                order_viol = 1'b1;
            end
        end
        order_err_d = capture ? order_viol : order_err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            order_err_q <= 1'b0;
        end else begin
            order_err_q <= order_err_d;
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule
